// File: rtl/multichan_tap_buffer.sv
// ============================================================================
// Module   : multichan_tap_buffer
// Brief    : Per-channel circular sample history with tap-by-age readback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multichan_tap_buffer #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int CHANNELS = 2,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CW-1:0]       in_chan,
  input  logic [WIDTH-1:0]    in_data,
  input  logic                clr,
  input  logic [CW-1:0]       clr_chan,
  input  logic                rd_en,
  input  logic [CW-1:0]       rd_chan,
  input  logic [TW-1:0]       rd_tap,
  output logic                rd_valid,
  output logic [WIDTH-1:0]    rd_data,
  output logic                rd_err,
  output logic [CHANNELS-1:0] chan_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = TW + 1;
  localparam logic [PW-1:0] c_last_ptr = PW'(DEPTH - 1);
  localparam logic [TW-1:0] c_depth    = TW'(DEPTH);

  logic [PW-1:0]    w_wptr  [CHANNELS];
  logic [TW-1:0]    w_fill  [CHANNELS];
  logic [WIDTH-1:0] w_rword [CHANNELS];

  logic             w_chan_ok;
  logic             w_tap_ok;
  logic             w_in_fill;
  logic [CW-1:0]    w_rc;
  logic [AW-1:0]    w_base;
  logic [AW-1:0]    w_sub;
  logic [PW-1:0]    w_ridx;

  logic             r_rd_valid;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_err;

  assign w_chan_ok = ({1'b0, rd_chan} < (CW+1)'(CHANNELS));
  assign w_tap_ok  = (rd_tap < c_depth);
  assign w_rc      = w_chan_ok ? rd_chan : '0;

  // (wptr-1-tap) mod DEPTH via one conditional add; valid for any DEPTH
  assign w_base    = AW'(w_wptr[w_rc]);
  assign w_sub     = AW'(rd_tap) + AW'(1);
  assign w_ridx    = (w_base >= w_sub) ? PW'(w_base - w_sub)
                                       : PW'(w_base + AW'(DEPTH) - w_sub);
  assign w_in_fill = (rd_tap < w_fill[w_rc]);

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic [PW-1:0]    r_wptr;
      logic [PW-1:0]    w_wptr_nxt;
      logic [PW-1:0]    w_waddr;
      logic [TW-1:0]    r_fill;
      logic [TW-1:0]    w_fill_nxt;
      logic             r_full;
      logic             w_wr;
      logic             w_clr;
      logic [WIDTH-1:0] r_mem [DEPTH];

      assign w_wr    = in_valid && (in_chan == CW'(c));
      assign w_clr   = clr && (clr_chan == CW'(c));
      // A write alongside a clear becomes the first sample of the new history
      assign w_waddr = w_clr ? '0 : r_wptr;

      always_comb begin
        w_wptr_nxt = w_waddr;
        w_fill_nxt = w_clr ? '0 : r_fill;
        if (w_wr) begin
          w_wptr_nxt = (w_waddr == c_last_ptr) ? '0 : w_waddr + PW'(1);
          if (w_fill_nxt != c_depth) begin
            w_fill_nxt = w_fill_nxt + TW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_wptr <= '0;
          r_fill <= '0;
          r_full <= 1'b0;
        end else begin
          r_wptr <= w_wptr_nxt;
          r_fill <= w_fill_nxt;
          r_full <= (w_fill_nxt == c_depth);
        end
      end

      always_ff @(posedge clk) begin
        if (w_wr) begin
          r_mem[w_waddr] <= in_data;
        end
      end

      assign w_wptr[c]    = r_wptr;
      assign w_fill[c]    = r_fill;
      assign w_rword[c]   = r_mem[w_ridx];
      assign chan_full[c] = r_full;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (!w_chan_ok || !w_tap_ok) begin
          r_rd_data <= '0;
          r_rd_err  <= 1'b1;
        end else begin
          r_rd_data <= w_in_fill ? w_rword[w_rc] : '0;
          r_rd_err  <= 1'b0;
        end
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign rd_err   = r_rd_err;

endmodule

`default_nettype wire

// File: tb/tb_multichan_tap_buffer.sv
// ============================================================================
// Module   : tb_multichan_tap_buffer
// Brief    : Directed bench for multichan_tap_buffer (64x2 and 48x3 instances).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multichan_tap_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic        a_in_valid = 1'b0;
  logic [0:0]  a_in_chan  = '0;
  logic [15:0] a_in_data  = '0;
  logic        a_clr      = 1'b0;
  logic [0:0]  a_clr_chan = '0;
  logic        a_rd_en    = 1'b0;
  logic [0:0]  a_rd_chan  = '0;
  logic [6:0]  a_rd_tap   = '0;
  logic        a_rd_valid;
  logic [15:0] a_rd_data;
  logic        a_rd_err;
  logic [1:0]  a_chan_full;

  logic        b_in_valid = 1'b0;
  logic [1:0]  b_in_chan  = '0;
  logic [15:0] b_in_data  = '0;
  logic        b_clr      = 1'b0;
  logic [1:0]  b_clr_chan = '0;
  logic        b_rd_en    = 1'b0;
  logic [1:0]  b_rd_chan  = '0;
  logic [6:0]  b_rd_tap   = '0;
  logic        b_rd_valid;
  logic [15:0] b_rd_data;
  logic        b_rd_err;
  logic [2:0]  b_chan_full;

  multichan_tap_buffer #(.WIDTH(16), .DEPTH(64), .CHANNELS(2)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_chan(a_in_chan), .in_data(a_in_data),
    .clr(a_clr), .clr_chan(a_clr_chan),
    .rd_en(a_rd_en), .rd_chan(a_rd_chan), .rd_tap(a_rd_tap),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err),
    .chan_full(a_chan_full)
  );

  multichan_tap_buffer #(.WIDTH(16), .DEPTH(48), .CHANNELS(3)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_chan(b_in_chan), .in_data(b_in_data),
    .clr(b_clr), .clr_chan(b_clr_chan),
    .rd_en(b_rd_en), .rd_chan(b_rd_chan), .rd_tap(b_rd_tap),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err),
    .chan_full(b_chan_full)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic a_push(input int ch, input int v);
    a_in_valid = 1'b1; a_in_chan = 1'(ch); a_in_data = 16'(v);
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic b_push(input int ch, input int v);
    b_in_valid = 1'b1; b_in_chan = 2'(ch); b_in_data = 16'(v);
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic a_rdchk(input string tag, input int ch, input int tap,
                         input int exp_data, input int exp_err);
    a_rd_en = 1'b1; a_rd_chan = 1'(ch); a_rd_tap = 7'(tap);
    tick();
    a_rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(a_rd_valid), 32'd1);
    chk({tag, "_data"},  32'(a_rd_data),  32'(exp_data));
    chk({tag, "_err"},   32'(a_rd_err),   32'(exp_err));
  endtask

  task automatic b_rdchk(input string tag, input int ch, input int tap,
                         input int exp_data, input int exp_err);
    b_rd_en = 1'b1; b_rd_chan = 2'(ch); b_rd_tap = 7'(tap);
    tick();
    b_rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(b_rd_valid), 32'd1);
    chk({tag, "_data"},  32'(b_rd_data),  32'(exp_data));
    chk({tag, "_err"},   32'(b_rd_err),   32'(exp_err));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(a_rd_valid), 32'd0);
    chk("rst_data",  32'(a_rd_data),  32'd0);
    chk("rst_err",   32'(a_rd_err),   32'd0);
    chk("rst_full_a", 32'(a_chan_full), 32'd0);
    chk("rst_full_b", 32'(b_chan_full), 32'd0);
    rst = 1'b0;
    tick();

    // Empty channel reads as zero with one cycle latency
    a_rdchk("t1_ch0_tap0", 0, 0, 0, 0);
    tick();
    chk("t1_valid_drop", 32'(a_rd_valid), 32'd0);

    for (int v = 1; v <= 5; v++) a_push(1, v);
    a_rdchk("t2_tap0", 1, 0, 5, 0);
    a_rdchk("t2_tap4", 1, 4, 1, 0);
    tick();
    chk("t2_hold_data",  32'(a_rd_data),  32'd1);
    chk("t2_hold_valid", 32'(a_rd_valid), 32'd0);
    a_rdchk("t2_tap5", 1, 5, 0, 0);
    chk("t2_full", 32'(a_chan_full), 32'd0);

    for (int v = 1; v <= 70; v++) begin
      a_push(0, v);
      if (v == 63) chk("t3_full_at63", 32'(a_chan_full), 32'd0);
      if (v == 64) chk("t3_full_at64", 32'(a_chan_full), 32'd1);
    end
    chk("t3_full_at70", 32'(a_chan_full), 32'd1);
    a_rdchk("t3_tap0",  0, 0,  70, 0);
    a_rdchk("t3_tap63", 0, 63, 7,  0);
    a_rdchk("t3_tap62", 0, 62, 8,  0);

    // Read in the same cycle as a write sees the pre-write newest sample
    a_push(0, 8);
    a_in_valid = 1'b1; a_in_chan = 1'b0; a_in_data = 16'd9;
    a_rd_en = 1'b1; a_rd_chan = 1'b0; a_rd_tap = 7'd0;
    tick();
    a_in_valid = 1'b0; a_rd_en = 1'b0;
    chk("t4_rw_same", 32'(a_rd_data), 32'd8);
    a_rdchk("t4_tap0", 0, 0, 9, 0);
    a_rdchk("t4_tap1", 0, 1, 8, 0);

    // Clear + write + read on a full channel in one cycle
    a_clr = 1'b1; a_clr_chan = 1'b0;
    a_in_valid = 1'b1; a_in_chan = 1'b0; a_in_data = 16'h55;
    a_rd_en = 1'b1; a_rd_chan = 1'b0; a_rd_tap = 7'd0;
    tick();
    a_clr = 1'b0; a_in_valid = 1'b0; a_rd_en = 1'b0;
    chk("t5_read_preclear", 32'(a_rd_data), 32'd9);
    chk("t5_full_clr", 32'(a_chan_full), 32'd0);
    a_rdchk("t5_tap0", 0, 0, 32'h55, 0);
    a_rdchk("t5_tap1", 0, 1, 0, 0);
    a_rdchk("t5_ch1_tap0", 1, 0, 5, 0);
    a_rdchk("t5_ch1_tap4", 1, 4, 1, 0);

    a_rdchk("t6_tap64", 0, 64, 0, 1);
    a_rdchk("t6_ok", 0, 0, 32'h55, 0);
    a_rdchk("t6_tap127", 0, 127, 0, 1);
    a_rdchk("t6_ok2", 0, 0, 32'h55, 0);
    a_rdchk("t6_tap63_empty", 0, 63, 0, 0);

    // Clear one channel while writing the other
    a_clr = 1'b1; a_clr_chan = 1'b1;
    a_in_valid = 1'b1; a_in_chan = 1'b0; a_in_data = 16'h66;
    tick();
    a_clr = 1'b0; a_in_valid = 1'b0;
    a_rdchk("t7_ch1_cleared", 1, 0, 0, 0);
    a_rdchk("t7_ch0_tap0", 0, 0, 32'h66, 0);
    a_rdchk("t7_ch0_tap1", 0, 1, 32'h55, 0);

    // Asynchronous reset with a read in flight
    for (int v = 0; v < 64; v++) a_push(1, 100 + v);
    chk("t8_full_ch1", 32'(a_chan_full), 32'd2);
    a_rdchk("t8_pre_err", 0, 64, 0, 1);
    a_rd_en = 1'b1; a_rd_chan = 1'b0; a_rd_tap = 7'd0;
    #2 rst = 1'b1;
    #1;
    chk("t8_arst_valid", 32'(a_rd_valid), 32'd0);
    chk("t8_arst_err",   32'(a_rd_err),   32'd0);
    chk("t8_arst_full",  32'(a_chan_full), 32'd0);
    tick();
    chk("t8_arst_drop",  32'(a_rd_valid), 32'd0);
    a_rd_en = 1'b0;
    rst = 1'b0;
    tick();
    a_rdchk("t8_post_rst", 0, 0, 0, 0);
    a_rdchk("t8_post_ch1", 1, 0, 0, 0);

    // DEPTH=48, CHANNELS=3 instance: wrap with non power-of-two depth
    for (int v = 1; v <= 70; v++) begin
      b_push(0, v);
      if (v == 47) chk("b_full_at47", 32'(b_chan_full), 32'd0);
      if (v == 48) chk("b_full_at48", 32'(b_chan_full), 32'd1);
    end
    b_rdchk("b_tap0",  0, 0,  70, 0);
    b_rdchk("b_tap47", 0, 47, 23, 0);
    b_rdchk("b_tap46", 0, 46, 24, 0);
    b_rdchk("b_chan3", 3, 0,  0,  1);
    b_rdchk("b_tap0b", 0, 0,  70, 0);
    b_rdchk("b_tap48", 0, 48, 0,  1);
    b_push(3, 32'h77);
    b_push(2, 32'hAB);
    b_rdchk("b_ch2_tap0", 2, 0, 32'hAB, 0);
    b_rdchk("b_ch2_tap1", 2, 1, 0, 0);
    b_rdchk("b_ch0_keep", 0, 0, 70, 0);
    b_rdchk("b_ch1_empty", 1, 0, 0, 0);
    chk("b_full_final", 32'(b_chan_full), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
